// File: rtl/fact_pkg.sv
// fact_pkg: shared types and constants for the factorial engine.
//   - fact_state_e : engine FSM state encoding (idle, busy, done)
//   - DefWidth     : default result width
//   - DefNWidth    : default operand width
//   - CycCntWidth  : width of the optional busy-cycle counter
//                    (present when FACT_ENGINE_CYCLE_COUNT_EN is defined)
package fact_pkg;

    localparam int unsigned DefWidth    = 32;
    localparam int unsigned DefNWidth   = 4;
    localparam int unsigned CycCntWidth = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } fact_state_e;

endpackage

// File: rtl/fact_engine_if.sv
// fact_engine_if: start/result bundle between the CPU-side wrapper and fact_engine.
//   GoPulse : wrapper -> engine, one-cycle start strobe
//   N       : wrapper -> engine, operand, sampled on an accepted GoPulse
//   Busy    : engine -> wrapper, computation in progress
//   Done    : engine -> wrapper, sticky completion flag
//   Err     : engine -> wrapper, sticky overflow flag (valid with Done)
//   Nf      : engine -> wrapper, result (valid with Done)
//   CycCnt  : engine -> wrapper, busy-cycle count; only with FACT_ENGINE_CYCLE_COUNT_EN
// Modports: master = wrapper side, slave = engine side.
interface fact_engine_if #(
    parameter int unsigned WIDTH   = fact_pkg::DefWidth,
    parameter int unsigned N_WIDTH = fact_pkg::DefNWidth
);
    logic               GoPulse;
    logic [N_WIDTH-1:0] N;
    logic               Busy;
    logic               Done;
    logic               Err;
    logic [WIDTH-1:0]   Nf;
`ifdef FACT_ENGINE_CYCLE_COUNT_EN
    logic [fact_pkg::CycCntWidth-1:0] CycCnt;

    modport master (output GoPulse, output N,
                    input Busy, input Done, input Err, input Nf, input CycCnt);
    modport slave  (input GoPulse, input N,
                    output Busy, output Done, output Err, output Nf, output CycCnt);
`else
    modport master (output GoPulse, output N,
                    input Busy, input Done, input Err, input Nf);
    modport slave  (input GoPulse, input N,
                    output Busy, output Done, output Err, output Nf);
`endif
endinterface

// File: rtl/fact_dp.sv
// fact_dp: factorial datapath. Holds the down-counter and running product,
// the double-width multiplier and the overflow / termination detects.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (cnt=0, prod=0)
//   load_i     : cnt <= n_i, prod <= 1
//   step_i     : prod <= prod*cnt (low half), cnt <= cnt-1
//   n_i        : operand to load
//   prod_o     : current running product
//   ovf_o      : prod*cnt does not fit in WIDTH bits
//   cnt_le1_o  : counter has reached 0 or 1, product is final
module fact_dp #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [N_WIDTH-1:0] n_i,
    output logic [WIDTH-1:0]   prod_o,
    output logic               ovf_o,
    output logic               cnt_le1_o
);

    logic [N_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     prod_q, prod_d;
    logic [2*WIDTH-1:0]   full;

    assign full      = (2*WIDTH)'(prod_q) * (2*WIDTH)'(cnt_q);
    assign ovf_o     = |full[2*WIDTH-1:WIDTH];
    assign cnt_le1_o = (cnt_q <= N_WIDTH'(1));
    assign prod_o    = prod_q;

    always_comb begin
        cnt_d  = cnt_q;
        prod_d = prod_q;
        if (load_i) begin
            cnt_d  = n_i;
            prod_d = WIDTH'(1);
        end else if (step_i) begin
            cnt_d  = cnt_q - N_WIDTH'(1);
            prod_d = full[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            prod_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
        end
    end

endmodule

// File: rtl/fact_engine.sv
// fact_engine: iterative factorial engine, one multiply per cycle.
//   Clk : clock, rising edge
//   Rst : synchronous active-high reset, overrides everything
//   bus : fact_engine_if.slave (GoPulse, N in; Busy, Done, Err, Nf out)
// Optional feature macro FACT_ENGINE_CYCLE_COUNT_EN adds bus.CycCnt, a
// saturating count of BUSY cycles of the latest run.
module fact_engine
    import fact_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned N_WIDTH = DefNWidth
) (
    input  logic          Clk,
    input  logic          Rst,
    fact_engine_if.slave  bus
);

    fact_state_e      state_q, state_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] nf_q, nf_d;

    logic             load, step;
    logic [WIDTH-1:0] prod;
    logic             ovf, cnt_le1;

    fact_dp #(
        .WIDTH   (WIDTH),
        .N_WIDTH (N_WIDTH)
    ) u_dp (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .load_i    (load),
        .step_i    (step),
        .n_i       (bus.N),
        .prod_o    (prod),
        .ovf_o     (ovf),
        .cnt_le1_o (cnt_le1)
    );

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        err_d   = err_q;
        nf_d    = nf_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.GoPulse) begin
                    load    = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Termination is checked before overflow: the product is final
                // once cnt<=1, so no further multiply is attempted.
                if (cnt_le1) begin
                    nf_d    = prod;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (ovf) begin
                    nf_d    = '0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            nf_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            nf_q    <= nf_d;
        end
    end

    assign bus.Busy = (state_q == StBusy);
    assign bus.Done = done_q;
    assign bus.Err  = err_q;
    assign bus.Nf   = nf_q;

`ifdef FACT_ENGINE_CYCLE_COUNT_EN
    logic [CycCntWidth-1:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (load) begin
            cyc_d = '0;
        end else if (state_q == StBusy && cyc_q != '1) begin
            cyc_d = cyc_q + CycCntWidth'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign bus.CycCnt = cyc_q;
`endif

endmodule

// File: tb/tb_fact_engine.sv
// tb_fact_engine: self-checking bench for fact_engine. A reference model
// computes n! with wide arithmetic and derives the expected latency.
// Build with FACT_ENGINE_CYCLE_COUNT_EN to also check CycCnt.
module tb_fact_engine;

    localparam int unsigned W  = 32;
    localparam int unsigned NW = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 Clk = ~Clk;

    fact_engine_if #(.WIDTH(W), .N_WIDTH(NW)) bus ();

    fact_engine #(.WIDTH(W), .N_WIDTH(NW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    // Expected result: multiply n*(n-1)*...*2 in 64 bits; overflow when the
    // running product leaves 32 bits. Latency is the multiply count at
    // overflow, else max(n,1).
    function automatic void model(input int n, output logic [W-1:0] nf,
                                  output bit err, output int lat);
        longint unsigned p = 1;
        int m = 0;
        err = 1'b0;
        lat = (n <= 1) ? 1 : n;
        for (int i = n; i >= 2; i--) begin
            p = p * longint'(i);
            m++;
            if ((p >> 32) != 0) begin
                err = 1'b1;
                lat = m;
                break;
            end
        end
        nf = err ? '0 : p[W-1:0];
    endfunction

    // Drive a one-cycle GoPulse; returns after edge k (+1 time unit).
    task automatic pulse_go(input int n);
        @(posedge Clk); #1;
        bus.GoPulse = 1'b1;
        bus.N       = NW'(n);
        @(posedge Clk); #1;
        bus.GoPulse = 1'b0;
    endtask

    // Counts edges after k until Done; cycles=-1 on timeout.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 64; c++) begin
            @(posedge Clk); #1;
            if (bus.Done === 1'b1) begin
                cycles = c;
                break;
            end
        end
    endtask

    // One complete run checked against the model.
    task automatic run_one(input string tag, input int n, input logic [W-1:0] prev_nf);
        logic [W-1:0] e_nf;
        bit           e_err;
        int           e_lat, lat;
        model(n, e_nf, e_err, e_lat);
        pulse_go(n);
        n_checks++;
        if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 || bus.Err !== 1'b0 || bus.Nf !== prev_nf) begin
            n_fail++;
            $display("FAIL %s_start n=%0d: Busy=%b Done=%b Err=%b Nf=%0d, want 1 0 0 %0d",
                     tag, n, bus.Busy, bus.Done, bus.Err, bus.Nf, prev_nf);
        end
        wait_done(lat);
        n_checks++;
        if (lat != e_lat || bus.Busy !== 1'b0 || bus.Err !== e_err || bus.Nf !== e_nf) begin
            n_fail++;
            $display("FAIL %s n=%0d: lat=%0d Busy=%b Err=%b Nf=%0d, want lat=%0d 0 %b %0d",
                     tag, n, lat, bus.Busy, bus.Err, bus.Nf, e_lat, e_err, e_nf);
        end
`ifdef FACT_ENGINE_CYCLE_COUNT_EN
        n_checks++;
        if (bus.CycCnt !== 16'(e_lat)) begin
            n_fail++;
            $display("FAIL %s_cyccnt n=%0d: got %0d want %0d", tag, n, bus.CycCnt, e_lat);
        end
`endif
        // Results must hold in DONE.
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if (bus.Done !== 1'b1 || bus.Err !== e_err || bus.Nf !== e_nf) begin
            n_fail++;
            $display("FAIL %s_hold n=%0d: Done=%b Err=%b Nf=%0d, want 1 %b %0d",
                     tag, n, bus.Done, bus.Err, bus.Nf, e_err, e_nf);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        bus.GoPulse = 1'b1;
        bus.N = 4'd7;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Err !== 1'b0 || bus.Nf !== '0) begin
            n_fail++;
            $display("FAIL reset: Busy=%b Done=%b Err=%b Nf=%0d, want all 0",
                     bus.Busy, bus.Done, bus.Err, bus.Nf);
        end
        bus.GoPulse = 1'b0;
        Rst = 1'b0;
    endtask

    task automatic test_directed();
        run_one("n5", 5, '0);
        run_one("n0", 0, 32'd120);
        run_one("n1", 1, 32'd1);
        run_one("n12", 12, 32'd1);
        run_one("n13", 13, 32'd479001600);
        run_one("n15", 15, '0);
        run_one("n2", 2, '0);
    endtask

    task automatic test_random();
        logic [W-1:0] prev, e_nf;
        bit           e_err;
        int           e_lat, n;
        prev = bus.Nf;
        for (int i = 0; i < 16; i++) begin
            n = int'($urandom_range(0, 15));
            run_one("rand", n, prev);
            model(n, e_nf, e_err, e_lat);
            prev = e_nf;
        end
    endtask

    task automatic test_go_ignored();
        pulse_go(6);
        bus.GoPulse = 1'b1;
        bus.N = 4'd2;
        // Held through the completing edge: must still be ignored there.
        for (int c = 1; c <= 6; c++) begin
            @(posedge Clk); #1;
            n_checks++;
            if (bus.Done !== (c == 6)) begin
                n_fail++;
                $display("FAIL busy_go c=%0d: Done=%b want %b", c, bus.Done, c == 6);
            end
        end
        bus.GoPulse = 1'b0;
        n_checks++;
        if (bus.Nf !== 32'd720 || bus.Err !== 1'b0 || bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_go_result: Nf=%0d Err=%b Busy=%b, want 720 0 0",
                     bus.Nf, bus.Err, bus.Busy);
        end
        run_one("after_busy", 3, 32'd720);
    endtask

    task automatic test_reset_abort();
        pulse_go(10);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b1;
        bus.GoPulse = 1'b1;
        bus.N = 4'd4;
        @(posedge Clk); #1;  // edge k+3
        Rst = 1'b0;
        bus.GoPulse = 1'b0;
        n_checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Err !== 1'b0 || bus.Nf !== '0) begin
            n_fail++;
            $display("FAIL abort: Busy=%b Done=%b Err=%b Nf=%0d, want all 0",
                     bus.Busy, bus.Done, bus.Err, bus.Nf);
        end
`ifdef FACT_ENGINE_CYCLE_COUNT_EN
        n_checks++;
        if (bus.CycCnt !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_cyccnt: got %0d want 0", bus.CycCnt);
        end
`endif
        for (int c = 0; c < 15; c++) begin
            @(posedge Clk); #1;
            n_checks++;
            if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet c=%0d: Done=%b Busy=%b, want 0 0",
                         c, bus.Done, bus.Busy);
            end
        end
        run_one("post_abort", 4, '0);
    endtask

    initial begin
        bus.GoPulse = 1'b0;
        bus.N = '0;
        test_reset();
        test_directed();
        test_go_ignored();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
